// File: rtl/exu_lsu.sv
// exu_lsu: load/store unit. Runs one AGU access at a time as a single
// request/response transaction on the core data bus. It adds a bus timeout,
// bus-error reporting, and draining of a late response after a timeout.
module exu_lsu #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_ag4ls_val,
  output logic        hs_ls4ag_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_err,
  output logic        o_dbus_req_val,
  input  logic        i_dbus_req_rdy,
  output logic [31:0] o_dbus_adr,
  output logic [31:0] o_dbus_wdat,
  output logic [3:0]  o_dbus_wen,
  output logic        o_dbus_ren,
  input  logic        i_dbus_rsp_val,
  output logic        o_dbus_rsp_rdy,
  input  logic [31:0] i_dbus_rdat,
  input  logic        i_dbus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [31:0]     rdat_q, rdat_d;
  logic [3:0]      wen_q, wen_d;
  logic            ren_q, ren_d;
  logic            err_q, err_d;
  logic            stale_q, stale_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic op;
  logic expire;
  // Byte-lane bits are dropped: the bus address is always word aligned.
  logic unused_adr_lo;

  assign unused_adr_lo = ^i_ls_adr[1:0];
  assign op            = hs_ag4ls_val & (i_ls_ren | (|i_ls_wen));
  // ">=" rather than "==": a request accepted exactly at the limit enters RSP
  // with the count already past TIMEOUT-1 and must still be able to expire.
  assign expire        = (cnt_q >= TO_LAST);

  // Next-state and datapath update for the access FSM.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    err_d   = err_q;
    stale_d = stale_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (stale_q) begin
          // Swallow the late beat of a timed-out access before taking new work.
          if (i_dbus_rsp_val) stale_d = 1'b0;
        end else if (op) begin
          adr_d   = {i_ls_adr[31:2], 2'b00};
          wdat_d  = i_ls_wdat;
          wen_d   = i_ls_wen;
          ren_d   = (|i_ls_wen) ? 1'b0 : i_ls_ren;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (i_dbus_req_rdy) begin
          state_d = RSP;
        end else if (expire) begin
          // Request withdrawn without acceptance: nothing will come back.
          err_d   = 1'b1;
          rdat_d  = '0;
          state_d = DONE;
        end
      end
      RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (i_dbus_rsp_val) begin
          rdat_d  = i_dbus_err ? 32'h0 : i_dbus_rdat;
          err_d   = i_dbus_err;
          state_d = DONE;
        end else if (expire) begin
          err_d   = 1'b1;
          rdat_d  = '0;
          stale_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared by the shared bus reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      wen_q   <= '0;
      ren_q   <= 1'b0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      err_q   <= err_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from registered state; bus fields are zero outside REQ.
  always_comb begin
    hs_ls4ag_rdy   = (state_q == DONE) | ((state_q == IDLE) & ~op & ~stale_q);
    o_ls_rdat      = rdat_q;
    o_ls_err       = (state_q == DONE) & err_q;
    o_dbus_req_val = (state_q == REQ);
    o_dbus_adr     = (state_q == REQ) ? adr_q  : 32'h0;
    o_dbus_wdat    = (state_q == REQ) ? wdat_q : 32'h0;
    o_dbus_wen     = (state_q == REQ) ? wen_q  : 4'h0;
    o_dbus_ren     = (state_q == REQ) & ren_q;
    o_dbus_rsp_rdy = (state_q == RSP) | ((state_q == IDLE) & stale_q);
  end

endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu: directed and randomized accesses against a transaction-level
// model of the LSU (latency, result and stale behaviour per access).
module tb_exu_lsu;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ag_val;
  logic        ls_rdy;
  logic [31:0] ls_adr, ls_wdat, ls_rdat;
  logic [3:0]  ls_wen;
  logic        ls_ren, ls_err;
  logic        req_val, req_rdy;
  logic [31:0] bus_adr, bus_wdat, bus_rdat;
  logic [3:0]  bus_wen;
  logic        bus_ren, rsp_val, rsp_rdy, bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exu_lsu #(.TIMEOUT(T), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .hs_ag4ls_val(ag_val), .hs_ls4ag_rdy(ls_rdy),
    .i_ls_adr(ls_adr), .i_ls_wdat(ls_wdat), .i_ls_wen(ls_wen), .i_ls_ren(ls_ren),
    .o_ls_rdat(ls_rdat), .o_ls_err(ls_err),
    .o_dbus_req_val(req_val), .i_dbus_req_rdy(req_rdy),
    .o_dbus_adr(bus_adr), .o_dbus_wdat(bus_wdat), .o_dbus_wen(bus_wen), .o_dbus_ren(bus_ren),
    .i_dbus_rsp_val(rsp_val), .o_dbus_rsp_rdy(rsp_rdy),
    .i_dbus_rdat(bus_rdat), .i_dbus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // One AGU access; bus stalls the request s cycles and holds the response w
  // cycles after acceptance. The expected outcome comes from the timing rules:
  // REQ+RSP may last TIMEOUT cycles, a handshake on the expiry cycle wins.
  task automatic run_access(input logic [31:0] adr, input logic [31:0] wdat,
                            input logic [3:0] wen, input logic ren,
                            input int s, input int w,
                            input logic [31:0] bdat, input logic berr,
                            input logic [31:0] late);
    int exp_lat, exp_acc, exp_reqc, cyc, reqc, rspc, nacc;
    logic exp_err, exp_stale, exp_ren, done;
    logic [31:0] exp_rdat;
    exp_ren  = (wen != 4'h0) ? 1'b0 : ren;
    exp_reqc = (s >= T) ? T : s + 1;
    if (s >= T) begin
      exp_lat = T + 1; exp_err = 1'b1; exp_rdat = 32'h0; exp_stale = 1'b0; exp_acc = 0;
    end else if (w == 0 || s + w + 2 <= T) begin
      exp_lat = s + w + 3; exp_err = berr; exp_rdat = berr ? 32'h0 : bdat;
      exp_stale = 1'b0; exp_acc = 1;
    end else begin
      exp_lat = ((s + 2 > T) ? s + 2 : T) + 1; exp_err = 1'b1; exp_rdat = 32'h0;
      exp_stale = 1'b1; exp_acc = 1;
    end

    @(negedge clk);
    ag_val = 1'b1; ls_adr = adr; ls_wdat = wdat; ls_wen = wen; ls_ren = ren;
    cyc = 0; reqc = 0; rspc = 0; nacc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      #1;
      if (ls_rdy) begin
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("rdat", ls_rdat, exp_rdat);
        chk("err", 32'(ls_err), 32'(exp_err));
        done = 1'b1;
        req_rdy = 1'b0; rsp_val = 1'b0;
      end else begin
        if (ls_err) chk("err_outside_done", 32'(ls_err), 32'h0);
        if (req_val) begin
          reqc++;
          chk("bus_adr", bus_adr, {adr[31:2], 2'b00});
          chk("bus_wdat", bus_wdat, wdat);
          chk("bus_wen", 32'(bus_wen), 32'(wen));
          chk("bus_ren", 32'(bus_ren), 32'(exp_ren));
          req_rdy = (reqc > s);
          if (req_rdy) nacc++;
        end else begin
          req_rdy = 1'b0;
        end
        if (rsp_rdy) begin
          rspc++;
          rsp_val  = (rspc > w);
          bus_rdat = bdat;
          bus_err  = rsp_val & berr;
        end else begin
          rsp_val = 1'b0; bus_err = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_seen", 32'h0, 32'h1);
    ag_val = 1'b0;
    chk("accepted", 32'(nacc), 32'(exp_acc));
    chk("req_cycles", 32'(reqc), 32'(exp_reqc));
    #1;
    if (exp_stale) begin
      chk("stale_blocks_rdy", 32'(ls_rdy), 32'h0);
      chk("stale_rsp_rdy", 32'(rsp_rdy), 32'h1);
      rsp_val = 1'b1; bus_rdat = late; bus_err = 1'b0;
      @(negedge clk);
      rsp_val = 1'b0;
      #1;
      chk("stale_cleared_rdy", 32'(ls_rdy), 32'h1);
      chk("stale_cleared_rsp", 32'(rsp_rdy), 32'h0);
    end else begin
      chk("idle_rdy", 32'(ls_rdy), 32'h1);
      chk("idle_rsp_rdy", 32'(rsp_rdy), 32'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_val"}, 32'(req_val), 32'h0);
    chk({tag, "_rsp_rdy"}, 32'(rsp_rdy), 32'h0);
    chk({tag, "_bus_adr"}, bus_adr, 32'h0);
    chk({tag, "_bus_wen"}, 32'(bus_wen), 32'h0);
    chk({tag, "_bus_ren"}, 32'(bus_ren), 32'h0);
    chk({tag, "_rdat"}, ls_rdat, 32'h0);
    chk({tag, "_err"}, 32'(ls_err), 32'h0);
  endtask

  initial begin
    logic [31:0] a, d, bd;
    logic [3:0]  we;
    logic        re, be;
    int          s, w;

    rst_n = 1'b0; ag_val = 1'b0; ls_adr = '0; ls_wdat = '0; ls_wen = '0; ls_ren = 1'b0;
    req_rdy = 1'b0; rsp_val = 1'b0; bus_rdat = '0; bus_err = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("reset_idle_rdy", 32'(ls_rdy), 32'h1);

    // Directed cases
    run_access(32'h0000_0104, 32'h0, 4'h0, 1'b1, 0, 0, 32'hDEAD_BEEF, 1'b0, 32'h0);
    run_access(32'h0000_0202, 32'h00AB_0000, 4'b0100, 1'b0, 3, 0, 32'h0, 1'b0, 32'h0);
    run_access(32'h0000_0300, 32'h0, 4'h0, 1'b1, 0, 0, 32'h1234_5678, 1'b1, 32'h0);
    run_access(32'h0000_0400, 32'h0, 4'h0, 1'b1, 0, 100, 32'h0, 1'b0, 32'h55);
    run_access(32'h0000_0404, 32'h0, 4'h0, 1'b1, 0, 0, 32'h66, 1'b0, 32'h0);
    run_access(32'h0000_0500, 32'h0, 4'h0, 1'b1, T, 0, 32'h77, 1'b0, 32'h0);
    run_access(32'h0000_0504, 32'h0, 4'h0, 1'b1, T - 1, 0, 32'h88, 1'b0, 32'h0);
    run_access(32'h0000_0508, 32'h0, 4'h0, 1'b1, T - 1, 1, 32'h99, 1'b0, 32'hAA);
    run_access(32'h0000_050C, 32'h0, 4'h0, 1'b1, 2, T - 4, 32'hBB, 1'b0, 32'h0);

    // No-op access completes in the same cycle without bus activity
    @(negedge clk);
    ag_val = 1'b1; ls_ren = 1'b0; ls_wen = 4'h0;
    #1;
    chk("noop_rdy", 32'(ls_rdy), 32'h1);
    chk("noop_req_val", 32'(req_val), 32'h0);
    @(negedge clk);
    #1;
    chk("noop_req_val_next", 32'(req_val), 32'h0);
    chk("noop_rdy_next", 32'(ls_rdy), 32'h1);
    ag_val = 1'b0;

    // Reset while waiting for a response
    @(negedge clk);
    ag_val = 1'b1; ls_adr = 32'h0000_0600; ls_ren = 1'b1; ls_wen = 4'h0;
    @(negedge clk);
    #1 chk("rst_case_in_req", 32'(req_val), 32'h1);
    req_rdy = 1'b1;
    @(negedge clk);
    req_rdy = 1'b0;
    #1 chk("rst_case_in_rsp", 32'(rsp_rdy), 32'h1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    ag_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_access(32'h0000_0608, 32'h0, 4'h0, 1'b1, 1, 1, 32'hCAFE_F00D, 1'b0, 32'h0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      d  = $urandom;
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      re = (we == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T - 1, T + 2)) : int'($urandom_range(0, 3));
      w  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T - 2, T + 4)) : int'($urandom_range(0, 3));
      bd = $urandom;
      be = ($urandom_range(0, 4) == 0);
      run_access(a, d, we, re, s, w, bd, be, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
